// File: rtl/debug_display_mux.sv
// Debug-probe display engine: selects a window of one probe channel, snapshots it,
// and scans it onto a multiplexed common-anode hex display.
module debug_display_mux #(
  parameter  int NUM_CH      = 8,
  parameter  int CH_W        = 32,
  parameter  int DIGITS      = 4,
  parameter  int REFRESH_DIV = 50000,
  parameter  int AUTO_DIV    = 100000000,
  localparam int NUM_WIN     = CH_W / (4 * DIGITS),
  localparam int CH_SEL_W    = $clog2(NUM_CH),
  localparam int WIN_SEL_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH*CH_W-1:0] probe_bus,
  input  logic [CH_SEL_W-1:0]    ch_sel,
  input  logic [WIN_SEL_W-1:0]   win_sel,
  input  logic                   auto_mode,
  input  logic                   freeze,
  output logic [6:0]             seven_segment,
  output logic [DIGITS-1:0]      anode,
  output logic [CH_SEL_W-1:0]    cur_ch,
  output logic [WIN_SEL_W-1:0]   cur_win
);

  localparam int SNAP_W = 4 * DIGITS;
  localparam int AC_W   = $clog2(AUTO_DIV);
  localparam int RC_W   = $clog2(REFRESH_DIV);
  localparam int DI_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CH_SEL_W-1:0]  r_cur_ch;
  logic [WIN_SEL_W-1:0] r_cur_win;
  logic [AC_W-1:0]      r_auto_cnt;
  logic [RC_W-1:0]      r_refresh_cnt;
  logic [DI_W-1:0]      r_digit_idx;
  logic [SNAP_W-1:0]    r_snapshot;
  logic [DIGITS-1:0]    r_anode;
  logic [6:0]           r_seg;

  logic                 w_ch_ok;
  logic                 w_win_ok;
  logic [CH_W-1:0]      w_ch_word;
  logic [SNAP_W-1:0]    w_window;
  logic [3:0]           w_nibble;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    w_ch_ok   = int'(ch_sel) < NUM_CH;
    w_win_ok  = int'(win_sel) < NUM_WIN;
    w_ch_word = probe_bus[int'(r_cur_ch) * CH_W +: CH_W];
    w_window  = w_ch_word[int'(r_cur_win) * SNAP_W +: SNAP_W];
    w_nibble  = r_snapshot[int'(r_digit_idx) * 4 +: 4];
  end

  // Position: manual load, or auto-advance window-major with channel carry; freeze holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_ch   <= '0;
      r_cur_win  <= '0;
      r_auto_cnt <= '0;
    end else begin
      if (!auto_mode)
        r_auto_cnt <= '0;
      if (!freeze) begin
        if (!auto_mode) begin
          r_cur_ch  <= w_ch_ok  ? ch_sel  : '0;
          r_cur_win <= w_win_ok ? win_sel : '0;
        end else if (r_auto_cnt == AC_W'(AUTO_DIV - 1)) begin
          r_auto_cnt <= '0;
          if (r_cur_win == WIN_SEL_W'(NUM_WIN - 1)) begin
            r_cur_win <= '0;
            r_cur_ch  <= (r_cur_ch == CH_SEL_W'(NUM_CH - 1)) ? '0 : r_cur_ch + CH_SEL_W'(1);
          end else begin
            r_cur_win <= r_cur_win + WIN_SEL_W'(1);
          end
        end else begin
          r_auto_cnt <= r_auto_cnt + AC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_snapshot <= '0;
    else if (!freeze)
      r_snapshot <= w_window;
  end

  // Refresh scan runs independently of mode and freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
    end else if (r_refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= (r_digit_idx == DI_W'(DIGITS - 1)) ? '0 : r_digit_idx + DI_W'(1);
    end else begin
      r_refresh_cnt <= r_refresh_cnt + RC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode <= '1;
      r_seg   <= '1;
    end else begin
      r_anode <= ~(DIGITS'(1) << r_digit_idx);
      r_seg   <= hex_decode(w_nibble);
    end
  end

  assign seven_segment = r_seg;
  assign anode         = r_anode;
  assign cur_ch        = r_cur_ch;
  assign cur_win       = r_cur_win;

endmodule

// File: tb/tb_debug_display_mux.sv
// Directed bench for debug_display_mux: reset, manual scan, out-of-range select,
// freeze, auto-cycle with freeze stretch, and reset mid-auto-step.
module tb_debug_display_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] probe;
  logic [1:0]   ch_sel;
  logic         win_sel;
  logic         auto_mode;
  logic         freeze;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic [1:0]   cur_ch;
  logic         cur_win;

  logic [159:0] probe5;
  logic [2:0]   ch_sel5;
  logic [6:0]   seg5;
  logic [3:0]   an5;
  logic [2:0]   cur_ch5;
  logic         cur_win5;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;

  logic [6:0] seg_abcd [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] seg_beef [4] = '{7'h0E, 7'h06, 7'h06, 7'h03};

  always #5 clk = ~clk;

  debug_display_mux #(
    .NUM_CH(4), .CH_W(32), .DIGITS(4), .REFRESH_DIV(4), .AUTO_DIV(16)
  ) u_dut (
    .clk(clk), .reset(reset), .probe_bus(probe), .ch_sel(ch_sel), .win_sel(win_sel),
    .auto_mode(auto_mode), .freeze(freeze), .seven_segment(seg), .anode(an),
    .cur_ch(cur_ch), .cur_win(cur_win)
  );

  debug_display_mux #(
    .NUM_CH(5), .CH_W(32), .DIGITS(4), .REFRESH_DIV(4), .AUTO_DIV(16)
  ) u_dut5 (
    .clk(clk), .reset(reset), .probe_bus(probe5), .ch_sel(ch_sel5), .win_sel(1'b0),
    .auto_mode(1'b0), .freeze(1'b0), .seven_segment(seg5), .anode(an5),
    .cur_ch(cur_ch5), .cur_win(cur_win5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Digit shown after edge k since reset release: dwell 4, 4 digits.
  function automatic int dig(input int kk);
    return ((kk - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] an_exp(input int d);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    return a;
  endfunction

  initial begin
    reset     = 1'b1;
    probe     = {$urandom, $urandom, $urandom, $urandom};
    ch_sel    = 2'($urandom);
    win_sel   = 1'($urandom);
    auto_mode = 1'($urandom);
    freeze    = 1'($urandom);
    probe5    = '0;
    ch_sel5   = '0;
    repeat (3) tick();
    chk("rst_anode", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_ch", 32'(cur_ch), 0);
    chk("rst_win", 32'(cur_win), 0);

    reset = 1'b0; probe = '0; ch_sel = 2'd0; win_sel = 1'b0; auto_mode = 1'b0; freeze = 1'b0;
    k = 0;
    tick();
    chk("rel_anode", 32'(an), 32'hE);
    chk("rel_seg", 32'(seg), 32'h40);

    probe[64 +: 32] = 32'h1234_ABCD;
    ch_sel = 2'd2; win_sel = 1'b1;
    tick();
    chk("man_ch", 32'(cur_ch), 2);
    chk("man_win", 32'(cur_win), 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("scan_anode", 32'(an), 32'(an_exp(dig(k))));
      chk("scan_seg", 32'(seg), 32'(seg_abcd[dig(k)]));
    end

    ch_sel5 = 3'd4;
    tick();
    chk("oor_ch4", 32'(cur_ch5), 4);
    ch_sel5 = 3'd5;
    tick();
    chk("oor_ch5", 32'(cur_ch5), 0);
    ch_sel5 = 3'd7;
    tick();
    chk("oor_ch7", 32'(cur_ch5), 0);

    ch_sel = 2'd0; win_sel = 1'b0;
    probe[0 +: 32] = 32'h0000_BEEF;
    tick();
    tick();
    freeze = 1'b1;
    tick();
    probe[0 +: 32] = 32'h0;
    ch_sel = 2'd3;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("frz_anode", 32'(an), 32'(an_exp(dig(k))));
      chk("frz_seg", 32'(seg), 32'(seg_beef[dig(k)]));
      chk("frz_ch", 32'(cur_ch), 0);
    end
    freeze = 1'b0; ch_sel = 2'd0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("unfrz_anode", 32'(an), 32'(an_exp(dig(k))));
      chk("unfrz_seg", 32'(seg), 32'h40);
    end

    tick();
    chk("auto_start_ch", 32'(cur_ch), 0);
    chk("auto_start_win", 32'(cur_win), 0);
    auto_mode = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      repeat (15) tick();
      chk("auto_hold", {30'd0, cur_ch, cur_win}, 32'(((((s - 1) / 2) % 4) * 2) + ((s - 1) % 2)));
      tick();
      chk("auto_step", {30'd0, cur_ch, cur_win}, 32'((((s / 2) % 4) * 2) + (s % 2)));
    end

    repeat (5) tick();
    freeze = 1'b1;
    repeat (10) tick();
    chk("afrz_hold", {30'd0, cur_ch, cur_win}, 32'h0);
    freeze = 1'b0;
    repeat (10) tick();
    chk("afrz_late", {30'd0, cur_ch, cur_win}, 32'h0);
    tick();
    chk("afrz_step", {30'd0, cur_ch, cur_win}, 32'h1);

    repeat (64 + 9) tick();
    chk("pre_rst_pos", {30'd0, cur_ch, cur_win}, 32'h5);
    reset = 1'b1;
    tick();
    chk("mid_rst_pos", {30'd0, cur_ch, cur_win}, 32'h0);
    chk("mid_rst_anode", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    repeat (15) tick();
    chk("post_rst_hold", {30'd0, cur_ch, cur_win}, 32'h0);
    tick();
    chk("post_rst_step", {30'd0, cur_ch, cur_win}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
